// File: rtl/led_pio_sched_pkg.sv
// rtl/led_pio_sched_pkg.sv - shared state encoding and constants for the LED PIO scheduler
package led_pio_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    HOLD  = 2'd3
  } sched_state_t;

  // Address of the PIO data register
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  // Width of the spacing counter; covers HOLD_CYCLES up to 2^20-1
  localparam int HOLD_CNT_W = 20;

  // Bit width needed to index n requesters (at least one bit)
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pio_scheduler_if.sv
// rtl/led_pio_scheduler_if.sv - PIO register bus between scheduler and LED PIO peripheral
interface led_pio_scheduler_if;

  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  // Scheduler side drives the bus, reads back data
  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_readdata
  );

  // PIO side observes the bus, returns register contents
  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_readdata
  );

endinterface

// File: rtl/led_pio_rr_arbiter.sv
// rtl/led_pio_rr_arbiter.sv - combinational round-robin pick starting after the last granted index
module led_pio_rr_arbiter
  import led_pio_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Walk candidates last+1, last+2, ... (mod NUM_REQ); first active one wins
  always_comb begin
    int cand;
    logic [IDX_W-1:0] cidx;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_idx) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cidx = IDX_W'(cand);
      if (!valid && req[cidx]) begin
        valid       = 1'b1;
        idx         = cidx;
        grant[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pio_scheduler.sv
// rtl/led_pio_scheduler.sv - round-robin LED pattern writer to a PIO with write spacing; LED_PIO_SCHED_READBACK_EN adds readback check
module led_pio_scheduler
  import led_pio_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int LED_W       = 4,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] pattern,
  output logic [NUM_REQ-1:0]       grant,
  led_pio_scheduler_if.master      avm,
  output logic                     busy,
  output logic                     readback_err
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? HOLD_CNT_W'(HOLD_CYCLES - 1) : '0;
  // Where the FSM goes once the PIO access is finished
  localparam sched_state_t AFTER_ACCESS = (HOLD_CYCLES == 0) ? IDLE : HOLD;

  sched_state_t state, next_state;

  logic [IDX_W-1:0]      last_idx;
  logic [NUM_REQ-1:0]    cur_grant;
  logic [LED_W-1:0]      cur_pat;
  logic [HOLD_CNT_W-1:0] hold_cnt;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               select;

  led_pio_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req      (req),
    .last_idx (last_idx),
    .grant    (arb_grant),
    .idx      (arb_idx),
    .valid    (arb_valid)
  );

  assign select = (state == IDLE) && arb_valid;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and bus/handshake outputs, all decoded from the current state
  always_comb begin
    next_state         = state;
    grant              = '0;
    busy               = (state != IDLE);
    avm.avm_address    = PIO_DATA_ADDR;
    avm.avm_chipselect = 1'b0;
    avm.avm_write_n    = 1'b1;
    avm.avm_writedata  = 32'h0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        avm.avm_chipselect = 1'b1;
        avm.avm_write_n    = 1'b0;
        avm.avm_writedata  = 32'(cur_pat);
        grant              = cur_grant;
`ifdef LED_PIO_SCHED_READBACK_EN
        next_state = READ;
`else
        next_state = AFTER_ACCESS;
`endif
      end
      READ: begin
        avm.avm_chipselect = 1'b1;
        next_state         = AFTER_ACCESS;
      end
      HOLD: begin
        // Leave as the counter reaches zero on this edge
        if (hold_cnt <= HOLD_CNT_W'(1)) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the winner's index and pattern only at the selection edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_idx  <= IDX_W'(NUM_REQ - 1);
      cur_grant <= '0;
      cur_pat   <= '0;
    end else if (select) begin
      last_idx  <= arb_idx;
      cur_grant <= arb_grant;
      cur_pat   <= pattern[arb_idx*LED_W +: LED_W];
    end
  end

  // Spacing counter: load on entry to HOLD, count down while in it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if ((next_state == HOLD) && (state != HOLD)) begin
      hold_cnt <= HOLD_LOAD;
    end else if ((state == HOLD) && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - HOLD_CNT_W'(1);
    end
  end

`ifdef LED_PIO_SCHED_READBACK_EN
  // Sticky flag: readback of the LED bits disagrees with what was written
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readback_err <= 1'b0;
    end else if ((state == READ) && (avm.avm_readdata[LED_W-1:0] != cur_pat)) begin
      readback_err <= 1'b1;
    end
  end
`else
  assign readback_err = 1'b0;
`endif

endmodule

// File: doc/led_pio_scheduler.md
LED_PIO_SCHEDULER -- requirements
Module: led_pio_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter LED_W, default 4, LED pattern width (1..32).
REQ-003 SHALL have parameter HOLD_CYCLES, default 1000, minimum clk cycles between successive PIO writes (0..2^20-1).
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  in  NUM_REQ  level request per requester.
REQ-007 SHALL have port pattern  in  NUM_REQ*LED_W  pattern per requester; slice i is requester i.
REQ-008 SHALL have port grant  out  NUM_REQ  one-hot, one-cycle pulse when the requester's pattern is written.
REQ-009 SHALL have port avm_address  out  2  PIO register address.
REQ-010 SHALL have port avm_chipselect  out  1  PIO select.
REQ-011 SHALL have port avm_write_n  out  1  PIO write strobe, active-low.
REQ-012 SHALL have port avm_writedata  out  32  PIO write data.
REQ-013 SHALL have port avm_readdata  in  32  PIO read data, combinational, zero wait states.
REQ-014 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-015 SHALL have port readback_err  out  1  sticky readback mismatch flag.

Function
REQ-016 SHALL implement states IDLE, WRITE, READ, HOLD.
REQ-017 IDLE: with any req bit high, SHALL select one via round-robin, latch index and pattern slice, go to WRITE next cycle; otherwise stay.
REQ-018 Round-robin SHALL search starting at (last granted index + 1) mod NUM_REQ; after reset index 0 has highest priority.
REQ-019 WRITE (exactly one cycle): chipselect=1, write_n=0, address=0, writedata=latched pattern zero-extended; grant bit of latched index high this cycle only.
REQ-020 From WRITE SHALL go to READ if readback compiled in, else to HOLD (or IDLE when HOLD_CYCLES=0).
REQ-021 READ (exactly one cycle): chipselect=1, write_n=1, address=0; SHALL compare avm_readdata[LED_W-1:0] with latched pattern; mismatch sets readback_err next edge.
REQ-022 HOLD: counter loaded with HOLD_CYCLES-1 on entry, decrements each cycle, exits to IDLE when 0; write-to-write spacing therefore at least HOLD_CYCLES+1 (+1 with readback) cycles.
REQ-023 Outside WRITE/READ: chipselect=0, write_n=1, address=0, writedata=0.
REQ-024 Pattern SHALL be sampled only at the IDLE selection edge; later pattern or req changes SHALL not affect the write in flight.
REQ-025 A req dropped before selection SHALL not be serviced; a req held high after its grant SHALL be serviced again in rotation.
REQ-026 readback_err SHALL stay high until reset.

Reset
REQ-027 Asynchronous reset SHALL force IDLE, pointer to select index 0 first, counter 0, grant 0, busy 0, readback_err 0, bus outputs to REQ-023 idle values, including mid-WRITE/READ/HOLD.

Configuration
REQ-028 Macro LED_PIO_SCHED_READBACK_EN defined: READ state and readback_err logic present.
REQ-029 Macro undefined: READ never entered, readback_err tied 0, avm_readdata ignored.

Structure
REQ-030 Package led_pio_sched_pkg SHALL hold state enum and constant PIO_DATA_ADDR=2'd0.
REQ-031 Round-robin selection SHALL be sub-module led_pio_rr_arbiter (req, last pointer in; one-hot grant, index out).

Verification
REQ-032 Single req[2]=1, pattern slice 2=4'hA: WRITE on cycle 2 after req, writedata=32'h0000000A, grant=4'b0100.
REQ-033 req=4'b1111 held, HOLD_CYCLES=3: grants in order 0,1,2,3,0; write-to-write spacing exactly 4 cycles (5 with readback).
REQ-034 Pattern slice changed during HOLD: next write of same requester uses value sampled at its own selection.
REQ-035 Readback enabled, PIO model returns 4'h5 for written 4'h6: readback_err=1 after READ, persists until reset_n low.
REQ-036 reset_n low during WRITE: chipselect=0, write_n=1, busy=0 immediately; after release req=4'b1010 grants index 1 first.
